// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO-mapped bus: device indices, control bit positions,
// address field bounds and the request record used by the bus initiator.
package io_bus_pkg;

  localparam logic [2:0] IO_DEV_LED = 3'd0;
  localparam logic [2:0] IO_DEV_VGA = 3'd1;
  localparam logic [2:0] IO_DEV_SD  = 3'd2;
  localparam logic [2:0] IO_DEV_PS2 = 3'd3;

  localparam int CTRL_WRITE = 1;
  localparam int CTRL_BYTE  = 0;

  localparam int IO_SPACE_BIT = 31;
  localparam int IO_DEV_HI    = 25;
  localparam int IO_DEV_LO    = 23;

  typedef struct packed {
    logic        write;
    logic        byte_op;
    logic [31:0] addr;
    logic [15:0] wdata;
  } io_req_t;

  // True when the address lies in IO space and selects one of the four devices.
  function automatic logic io_addr_mapped(input logic [31:0] addr);
    return addr[IO_SPACE_BIT] && (addr[IO_DEV_HI:IO_DEV_LO] <= IO_DEV_PS2);
  endfunction

endpackage

// File: rtl/io_resp_fifo.sv
// First-word fall-through response FIFO; output word is zero while empty so the
// response port reads as all-zero after reset.
module io_resp_fifo
  import io_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/io_bus_initiator.sv
// Master-side driver for the IO bus: registered one-cycle issue, fixed-latency read
// capture and credit-limited FWFT responses. Optional macro: IO_INIT_ADDR_CHECK_EN.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int RESP_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] address_io,
  output logic [1:0]  control_io,
  output logic [15:0] data_in_io,
  input  logic [15:0] data_out_io
);

  localparam int UW = $clog2(RESP_DEPTH) + 1;

  io_req_t                 w_req;
  logic                    w_accept;
  logic                    w_mapped;
  logic                    w_acc_read;
  logic                    w_capture;
  logic                    w_pop;
  logic [UW-1:0]           w_used_next;
  logic [16:0]             w_push_word;
  logic [16:0]             w_fifo_out;

  logic [31:0]             r_addr;
  logic [1:0]              r_ctrl;
  logic [15:0]             r_wdata;
  logic                    r_bus_rd;
  logic                    r_bus_err;
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_err;
  logic [UW-1:0]           r_used;
  logic                    r_req_ready;

  assign w_req = '{write: req_write, byte_op: req_byte, addr: req_addr, wdata: req_wdata};

`ifdef IO_INIT_ADDR_CHECK_EN
  assign w_mapped = io_addr_mapped(w_req.addr);
`else
  assign w_mapped = 1'b1;
`endif

  assign w_accept    = req_valid && r_req_ready;
  assign w_acc_read  = w_accept && !w_req.write;
  assign w_capture   = r_tag_vld[READ_LATENCY-1];
  assign w_pop       = rsp_valid && rsp_ready;
  // Credits cover both reads still on the bus and words waiting in the FIFO.
  assign w_used_next = r_used + UW'(w_acc_read) - UW'(w_pop);

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_addr      <= '0;
      r_ctrl      <= '0;
      r_wdata     <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_used      <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_addr  <= '0;
      r_ctrl  <= '0;
      r_wdata <= '0;
      if (w_accept && w_mapped) begin
        r_addr             <= w_req.addr;
        r_ctrl[CTRL_WRITE] <= w_req.write;
        r_ctrl[CTRL_BYTE]  <= w_req.byte_op;
        r_wdata            <= w_req.wdata;
      end
      r_bus_rd    <= w_acc_read;
      r_bus_err   <= w_acc_read && !w_mapped;
      r_used      <= w_used_next;
      r_req_ready <= (w_used_next < UW'(RESP_DEPTH));
    end
  end

  // Tag pipeline tracks each bus read until the responder's data is due.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_tag_vld <= '0;
      r_tag_err <= '0;
    end else begin
      r_tag_vld[0] <= r_bus_rd;
      r_tag_err[0] <= r_bus_err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_err[i] <= r_tag_err[i-1];
      end
    end
  end

  assign w_push_word = r_tag_err[READ_LATENCY-1] ? 17'h10000 : {1'b0, data_out_io};

  io_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (17)
  ) u_resp_fifo (
    .i_clk   (main_clk),
    .i_rst_n (main_rst_n),
    .i_push  (w_capture),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_valid (rsp_valid),
    .o_data  (w_fifo_out)
  );

  assign rsp_data   = w_fifo_out[15:0];
  assign rsp_err    = w_fifo_out[16];
  assign req_ready  = r_req_ready;
  assign address_io = r_addr;
  assign control_io = r_ctrl;
  assign data_in_io = r_wdata;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Bench for io_bus_initiator: a 2-stage responder model, a transaction-level
// reference checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_io_bus_initiator;

  logic        main_clk   = 1'b0;
  logic        main_rst_n = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_write  = 1'b0;
  logic        req_byte   = 1'b0;
  logic [31:0] req_addr   = 32'h0;
  logic [15:0] req_wdata  = 16'h0;
  logic        rsp_ready  = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [31:0] address_io;
  logic [1:0]  control_io;
  logic [15:0] data_in_io;
  logic [15:0] data_out_io;

  int checks   = 0;
  int failures = 0;

  always #5 main_clk = ~main_clk;

  io_bus_initiator dut (
    .main_clk    (main_clk),
    .main_rst_n  (main_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_byte    (req_byte),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .address_io  (address_io),
    .control_io  (control_io),
    .data_in_io  (data_in_io),
    .data_out_io (data_out_io)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Responder contents: two named locations, everything else derived from the address.
  function automatic logic [15:0] resp_word(input logic [31:0] a);
    case (a)
      32'h80800010: return 16'hBEEF;
      32'h80800011: return 16'h00AB;
      default:      return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [15:0] resp_value(input logic [31:0] a, input logic b);
    logic [15:0] w;
    w = resp_word(a);
    return b ? {8'h00, w[7:0]} : w;
  endfunction

  function automatic logic mapped(input logic [31:0] a);
`ifdef IO_INIT_ADDR_CHECK_EN
    return a[31] && (a[25:23] < 3'd4);
`else
    return (a === a);
`endif
  endfunction

  logic [15:0] r_s1 = 16'h0;
  logic [15:0] r_s2 = 16'h0;
  always @(posedge main_clk) begin
    r_s1 <= resp_value(address_io, control_io[0]);
    r_s2 <= r_s1;
  end
  assign data_out_io = r_s2;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          avail;
  } rsp_t;

  rsp_t        mq[$];
  int          cyc    = 0;
  int          used_m = 0;
  logic [31:0] eb_addr = 32'h0;
  logic [1:0]  eb_ctrl = 2'b0;
  logic [15:0] eb_data = 16'h0;

  // Reference: credits, bus image and response timing from the transaction rules.
  always @(negedge main_clk) begin : cmp
    logic exp_ready;
    logic exp_valid;
    logic acc;
    rsp_t e;
    if (!main_rst_n) begin
      mq.delete();
      used_m  = 0;
      eb_addr = 32'h0;
      eb_ctrl = 2'b0;
      eb_data = 16'h0;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_address_io", address_io, 32'h0);
      check("rst_control_io", {30'd0, control_io}, 32'd0);
      check("rst_data_in_io", {16'd0, data_in_io}, 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    end else begin
      exp_ready = (used_m < 4);
      exp_valid = (mq.size() > 0) && (mq[0].avail <= cyc);
      check("model_req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      check("model_address_io", address_io, eb_addr);
      check("model_control_io", {30'd0, control_io}, {30'd0, eb_ctrl});
      check("model_data_in_io", {16'd0, data_in_io}, {16'd0, eb_data});
      check("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("model_rsp_data", {16'd0, rsp_data}, {16'd0, mq[0].data});
        check("model_rsp_err", {31'd0, rsp_err}, {31'd0, mq[0].err});
      end
      acc     = req_valid && exp_ready;
      eb_addr = 32'h0;
      eb_ctrl = 2'b0;
      eb_data = 16'h0;
      if (acc && mapped(req_addr)) begin
        eb_addr = req_addr;
        eb_ctrl = {req_write, req_byte};
        eb_data = req_wdata;
      end
      if (acc && !req_write) begin
        e.data  = mapped(req_addr) ? resp_value(req_addr, req_byte) : 16'h0;
        e.err   = !mapped(req_addr);
        e.avail = cyc + 4;
        mq.push_back(e);
        used_m++;
      end
      if (exp_valid && rsp_ready) begin
        void'(mq.pop_front());
        used_m--;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic send(input logic w, input logic b, input logic [31:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) check("send_ready_timeout", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_wdata = 16'h0;
  endtask

  task automatic wait_rsp(output int k);
    k = 1;
    while (!rsp_valid && k < 12) begin
      tick();
      k++;
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_bp [8] = '{16'h5A7A, 16'h5A78, 16'h5A7E, 16'h5A7C,
                              16'h5A72, 16'h5A70, 16'h5A76, 16'h5A74};

  initial begin : stim
    int k;
    int acc_n;
    int n;
    logic [15:0] got[$];
    logic [15:0] g;

    repeat (3) tick();
    check("init_req_ready", {31'd0, req_ready}, 32'd1);
    check("init_address_io", address_io, 32'h0);
    main_rst_n = 1'b1;
    tick();

    // Single write: one bus cycle, then idle, no response.
    send(1'b1, 1'b0, 32'h80000003, 16'h0001);
    check("wr_address_io", address_io, 32'h80000003);
    check("wr_control_io", {30'd0, control_io}, 32'd2);
    check("wr_data_in_io", {16'd0, data_in_io}, 32'h0001);
    tick();
    check("wr_idle_address", address_io, 32'h0);
    check("wr_idle_control", {30'd0, control_io}, 32'd0);
    repeat (4) tick();
    check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Word read with latency measured from accept.
    send(1'b0, 1'b0, 32'h80800010, 16'h0);
    check("rd_control_io", {30'd0, control_io}, 32'd0);
    wait_rsp(k);
    check("rd_accept_to_valid", k, 32'd4);
    check("rd_data", {16'd0, rsp_data}, 32'hBEEF);
    pop_one();

    // Byte read.
    send(1'b0, 1'b1, 32'h80800011, 16'h0);
    check("rdb_control_io", {30'd0, control_io}, 32'd1);
    wait_rsp(k);
    check("rdb_accept_to_valid", k, 32'd4);
    check("rdb_data", {16'd0, rsp_data}, 32'h00AB);
    pop_one();
    tick();

    // Eight reads against a stalled response port: credits stop at four.
    acc_n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h80800020;
    for (int c = 0; c < 10; c++) begin
      if (req_valid && req_ready) acc_n++;
      tick();
      if (acc_n < 8) req_addr = 32'h80800020 + 32'(2 * acc_n);
      else req_valid = 1'b0;
    end
    check("bp_accepted", acc_n, 32'd4);
    check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      if (rsp_valid) got.push_back(rsp_data);
      if (req_valid && req_ready) acc_n++;
      tick();
      if (acc_n < 8) req_addr = 32'h80800020 + 32'(2 * acc_n);
      else req_valid = 1'b0;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_rsp_count", got.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      g = (i < got.size()) ? got[i] : 16'hDEAD;
      check("bp_rsp_order", {16'd0, g}, {16'd0, exp_bp[i]});
    end
    tick();

    // Mixed traffic with a throttled response port: simultaneous push and pop.
    for (int c = 0; c < 24; c++) begin
      req_valid = (c < 16);
      req_write = (c % 3 == 1);
      req_byte  = (c % 4 == 2);
      req_addr  = 32'h80800100 + 32'(c);
      req_wdata = 16'(c * 7);
      rsp_ready = (c % 5 != 0);
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_wdata = 16'h0;
    rsp_ready = 1'b1;
    repeat (12) tick();
    rsp_ready = 1'b0;
    check("mix_drained", {31'd0, rsp_valid}, 32'd0);
    check("mix_ready", {31'd0, req_ready}, 32'd1);

    // Reset with two reads on the bus.
    acc_n = 0;
    n = 0;
    req_valid = 1'b1; req_addr = 32'h80800040;
    while (acc_n < 2 && n < 20) begin
      if (req_ready) acc_n++;
      tick();
      n++;
      req_addr = 32'h80800042;
    end
    req_valid = 1'b0; req_addr = 32'h0;
    check("rst_two_accepted", acc_n, 32'd2);
    main_rst_n = 1'b0;
    repeat (2) tick();
    main_rst_n = 1'b1;
    tick();
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_address_io", address_io, 32'h0);
    repeat (6) tick();
    check("post_rst_no_stale", {31'd0, rsp_valid}, 32'd0);

`ifdef IO_INIT_ADDR_CHECK_EN
    send(1'b0, 1'b0, 32'h00001000, 16'h0);
    check("um_rd_address_idle", address_io, 32'h0);
    check("um_rd_control_idle", {30'd0, control_io}, 32'd0);
    wait_rsp(k);
    check("um_rd_latency", k, 32'd4);
    check("um_rd_data", {16'd0, rsp_data}, 32'h0);
    check("um_rd_err", {31'd0, rsp_err}, 32'd1);
    pop_one();
    send(1'b1, 1'b0, 32'h82000000, 16'h1234);
    check("um_wr_address_idle", address_io, 32'h0);
    repeat (5) tick();
    check("um_wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_initiator.md
Name: io_bus_initiator

Overview:
- Master-side driver for the IO-mapped bus: accepts a valid/ready request stream and issues one word or byte access per cycle on address_io/control_io/data_in_io.
- Captures data_out_io for reads at the responder's fixed 2-cycle read latency and returns read data in program order through a buffered response stream.
- Sits between any bus agent (CPU core, future DMA/boot loader) and the IO decoder.

Parameters:
- RESP_DEPTH, 4, response FIFO entries; power of two, at least 4.
- READ_LATENCY, 2, register stages inside the responder between the address being driven and data_out_io being valid.

Ports:
- main_clk  in  1  sole clock.
- main_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_byte  in  1  byte access.
- req_addr  in  32  byte address; bit 31 = IO space, [25:23] = device index.
- req_wdata  in  16  write data; a byte write uses [7:0].
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  16  read data; byte reads are zero-extended.
- rsp_err  out  1  unmapped-access flag (see Optional Feature).
- address_io  out  32  bus address.
- control_io  out  2  {do_partial_write_instant, do_byte_operation_instant}.
- data_in_io  out  16  bus write data.
- data_out_io  in  16  bus read data.

Behaviour:
- Reset values: all outputs 0 except req_ready, which is 1. The response FIFO is emptied and all in-flight reads are discarded. Reset asserted mid-operation drops every pending response and never issues a partial write.
- Issue: a request accepted at edge E drives address_io/control_io/data_in_io from registers during the cycle after E, for exactly one cycle.
  - control_io[1] = req_write; control_io[0] = req_byte.
  - data_in_io = req_wdata unchanged; the responder replicates the low byte itself.
- Idle cycle (nothing accepted): address_io = 0, control_io = 0, data_in_io = 0. This is a harmless read with no side effects.
- Throughput: one accepted request per cycle, any mix of reads and writes. No bubbles are inserted, and bus order equals acceptance order.
- Read capture: for a read driven in bus cycle N, data_out_io is sampled at the edge that ends cycle N+READ_LATENCY. A READ_LATENCY-deep shift register of valid bits carries the in-flight tags.
- Captured data is written into the FIFO. rsp_valid first rises in cycle N+READ_LATENCY+1, so accept-to-rsp_valid is 4 cycles at the defaults.
- Credits: used = in-flight reads + FIFO occupancy.
  - An accepted read increments used; a response pop decrements it. Both in the same cycle leave it unchanged.
  - req_ready = (used < RESP_DEPTH), from registers only, with no combinational path from rsp_ready.
  - req_ready gates writes as well as reads.
  - The FIFO therefore never overflows, and data_out_io is never lost.
- FIFO: first-word fall-through. rsp_data and rsp_err are valid whenever rsp_valid is high, and hold stable while rsp_ready is low. Pointers wrap modulo RESP_DEPTH. Push and pop in the same cycle are legal, including when the FIFO is full and when it is empty.
- Writes produce no response.

Optional Feature:
- IO_INIT_ADDR_CHECK_EN defined:
  - A request with req_addr[31]==0 or req_addr[25:23]>=4 is accepted but not driven on the bus; an idle cycle is issued in its place.
  - An unmapped read still consumes a credit and completes in the normal latency slot, with rsp_data = 16'h0000 and rsp_err = 1.
  - An unmapped write is dropped silently.
- Not defined: every request is driven on the bus and rsp_err is tied to 0.

Decomposition:
- Package io_bus_pkg holds:
  - device index constants: IO_DEV_LED=0, IO_DEV_VGA=1, IO_DEV_SD=2, IO_DEV_PS2=3;
  - control bit positions CTRL_WRITE=1, CTRL_BYTE=0;
  - IO_SPACE_BIT=31 and the device field bounds 25:23;
  - a packed io_req_t struct {write, byte_op, addr, wdata}.
- Sub-module io_resp_fifo: parameterised depth, FWFT, width 17 ({err, data}).

Test Plan:
- Write 0x0001 to 0x80000003 -> one cycle on the bus with control_io=2'b10 and address_io=0x80000003; bus idle next cycle; no response.
- Read 0x80800010 with a responder model returning 0xBEEF at latency 2 -> rsp_valid in the 4th cycle after accept, rsp_data=0xBEEF.
- Byte read 0x80800011 with the responder returning 0x00AB -> control_io=2'b01; rsp_data=0x00AB.
- Eight back-to-back reads with rsp_ready held low, RESP_DEPTH=4 -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> 8 responses in order with no data lost; sustained one-per-cycle flow once credits recycle.
- Push and pop in the same cycle while full and while draining -> occupancy steady and no duplicate or dropped entry. Reset pulsed with 2 reads in flight -> after reset rsp_valid=0, req_ready=1, address_io=0.
- IO_INIT_ADDR_CHECK_EN: read 0x00001000 -> bus stays idle; rsp_data=0x0000 and rsp_err=1 after 4 cycles.
